// File: rtl/atmospheric_light_estimator_pkg.sv
// rtl/atmospheric_light_estimator_pkg.sv - shared constants for the atmospheric light estimator
// Purpose: FSM state encoding, channel width and min-channel select codes.
package atmospheric_light_estimator_pkg;

   localparam int CH_W = 8;

   typedef logic [CH_W-1:0] chan_t;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Channel select codes reported by the min-of-three comparator
   localparam logic [1:0] SEL_RED   = 2'd0;
   localparam logic [1:0] SEL_GREEN = 2'd1;
   localparam logic [1:0] SEL_BLUE  = 2'd2;

endpackage

// File: rtl/atmospheric_light_estimator_dark_channel_min3.sv
// rtl/atmospheric_light_estimator_dark_channel_min3.sv - combinational 3-input channel minimum
// Purpose: dark-channel value of one pixel plus which channel supplied it.
// Ports:
//   i_r, i_g, i_b : pixel channels
//   o_min         : min(r, g, b)
//   o_sel         : SEL_RED / SEL_GREEN / SEL_BLUE; ties resolve R, then G, then B
module dark_channel_min3
   import atmospheric_light_estimator_pkg::*;
(
   input  logic [CH_W-1:0] i_r,
   input  logic [CH_W-1:0] i_g,
   input  logic [CH_W-1:0] i_b,
   output logic [CH_W-1:0] o_min,
   output logic [1:0]      o_sel
);

   always_comb begin
      o_min = i_b;
      o_sel = SEL_BLUE;
      if ((i_r <= i_g) && (i_r <= i_b)) begin
         o_min = i_r;
         o_sel = SEL_RED;
      end else if (i_g <= i_b) begin
         o_min = i_g;
         o_sel = SEL_GREEN;
      end
   end

endmodule

// File: rtl/atmospheric_light_estimator.sv
// rtl/atmospheric_light_estimator.sv - per-frame brightest dark-channel pixel selector
// Purpose: sequences one RGB frame through a min-channel stage and keeps the pixel
//          with the largest dark-channel value as atmospheric light A.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : frame request (IDLE only) / synchronous discard
//   in_valid, in_ready    : pixel handshake; in_ready high only while accumulating
//   in_r, in_g, in_b      : pixel channels
//   busy, done, a_valid   : frame in progress / one-cycle publish pulse / A holds a result
//   A_r, A_g, A_b, A_dc   : selected pixel and its dark-channel value
module atmospheric_light_estimator
   import atmospheric_light_estimator_pkg::*;
#(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH_W-1:0] in_r,
   input  logic [CH_W-1:0] in_g,
   input  logic [CH_W-1:0] in_b,
   output logic            busy,
   output logic            done,
   output logic            a_valid,
   output logic [CH_W-1:0] A_r,
   output logic [CH_W-1:0] A_g,
   output logic [CH_W-1:0] A_b,
   output logic [CH_W-1:0] A_dc
);

   localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic             r_s1_valid;
   chan_t            r_s1_r, r_s1_g, r_s1_b, r_s1_dc;

   logic             r_have_best;
   chan_t            r_best_r, r_best_g, r_best_b, r_best_dc;

   logic             r_a_valid;
   chan_t            r_a_r, r_a_g, r_a_b, r_a_dc;

   chan_t            w_min_dc;
   logic [1:0]       w_min_sel;
   logic             w_unused_sel;
   logic             w_hs;
   logic             w_upd;
   chan_t            w_nxt_r, w_nxt_g, w_nxt_b, w_nxt_dc;

   dark_channel_min3 u_min3 (
      .i_r   (in_r),
      .i_g   (in_g),
      .i_b   (in_b),
      .o_min (w_min_dc),
      .o_sel (w_min_sel)
   );

   // Only the value matters for selection; which channel won is not tracked.
   assign w_unused_sel = ^w_min_sel;

   assign in_ready = (r_state == ST_ACCUM);
   assign busy     = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
   assign done     = (r_state == ST_DONE);
   assign w_hs     = in_valid && in_ready;

   // Strict compare keeps the earliest pixel on ties.
   assign w_upd = r_s1_valid && (!r_have_best || (r_s1_dc > r_best_dc));

   // Best-so-far including the pixel currently in stage 1; lets A be loaded on
   // the same edge that finalises the best registers.
   assign w_nxt_r  = w_upd ? r_s1_r  : r_best_r;
   assign w_nxt_g  = w_upd ? r_s1_g  : r_best_g;
   assign w_nxt_b  = w_upd ? r_s1_b  : r_best_b;
   assign w_nxt_dc = w_upd ? r_s1_dc : r_best_dc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_r      <= '0;
         r_s1_g      <= '0;
         r_s1_b      <= '0;
         r_s1_dc     <= '0;
         r_have_best <= 1'b0;
         r_best_r    <= '0;
         r_best_g    <= '0;
         r_best_b    <= '0;
         r_best_dc   <= '0;
         r_a_valid   <= 1'b0;
         r_a_r       <= '0;
         r_a_g       <= '0;
         r_a_b       <= '0;
         r_a_dc      <= '0;
      end else begin
         r_s1_valid <= 1'b0;

         // Stage 2: running maximum of the dark channel
         if (w_upd) begin
            r_best_r    <= r_s1_r;
            r_best_g    <= r_s1_g;
            r_best_b    <= r_s1_b;
            r_best_dc   <= r_s1_dc;
            r_have_best <= 1'b1;
         end

         if (abort) begin
            r_state   <= ST_IDLE;
            r_a_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_state     <= ST_ACCUM;
                     r_cnt       <= '0;
                     r_have_best <= 1'b0;
                     r_best_r    <= '0;
                     r_best_g    <= '0;
                     r_best_b    <= '0;
                     r_best_dc   <= '0;
                     r_a_valid   <= 1'b0;
                     r_a_r       <= '0;
                     r_a_g       <= '0;
                     r_a_b       <= '0;
                     r_a_dc      <= '0;
                  end
               end
               ST_ACCUM: begin
                  if (w_hs) begin
                     r_s1_valid <= 1'b1;
                     r_s1_r     <= in_r;
                     r_s1_g     <= in_g;
                     r_s1_b     <= in_b;
                     r_s1_dc    <= w_min_dc;
                     r_cnt      <= r_cnt + 1'b1;
                     if (r_cnt == LAST_IDX) begin
                        r_state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  r_state   <= ST_DONE;
                  r_a_valid <= 1'b1;
                  r_a_r     <= w_nxt_r;
                  r_a_g     <= w_nxt_g;
                  r_a_b     <= w_nxt_b;
                  r_a_dc    <= w_nxt_dc;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign a_valid = r_a_valid;
   assign A_r     = r_a_r;
   assign A_g     = r_a_g;
   assign A_b     = r_a_b;
   assign A_dc    = r_a_dc;

endmodule

// File: doc/atmospheric_light_estimator.md
# atmospheric_light_estimator

Frame-level controller that sequences a per-pixel minimum-channel comparator over one RGB frame and records the pixel with the brightest dark-channel value as the atmospheric light estimate A. Sits after the input pixel stream and ahead of the transmission-estimation stage; it runs once per frame on `start` and publishes A_r/A_g/A_b with a done pulse.

## Interface
- `IMG_WIDTH`, default 512: pixels per line.
- `IMG_HEIGHT`, default 512: lines per frame.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `abort`  in  1  synchronous; returns to IDLE and discards the current frame.
- `in_valid`  in  1  pixel present.
- `in_ready`  out  1  block accepts a pixel; high only in ACCUM.
- `in_r`, `in_g`, `in_b`  in  8 each  pixel channels.
- `busy`  out  1  high in ACCUM or DRAIN.
- `done`  out  1  one-cycle pulse when A is published.
- `a_valid`  out  1  A_* hold a completed estimate; cleared on accepted `start`.
- `A_r`, `A_g`, `A_b`  out  8 each  RGB of the selected pixel.
- `A_dc`  out  8  dark-channel value of the selected pixel.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: `start`=1 and `abort`=0 -> ACCUM; clear pixel counter, `have_best`, best registers and `a_valid`.
- ACCUM: handshake when `in_valid` && `in_ready`. Each accepted pixel is captured into stage-1 registers with `dc = min(r,g,b)`, and the counter increments. On the handshake with counter = IMG_WIDTH*IMG_HEIGHT-1, go to DRAIN.
- Stage 2, any cycle with stage-1 valid: if `have_best`=0 or `dc` > `best_dc` (strict), load `best_{r,g,b,dc}` and set `have_best`. On ties the earliest pixel in raster order wins.
- DRAIN: one cycle so the last pixel passes through stage 2, then go to DONE.
- DONE: `done`=1 and `a_valid` set for one cycle, then go to IDLE. A_* keep their value until the next accepted `start`.
- `abort` in any state: go to IDLE next edge, clear stage-1 valid and `a_valid`, no `done`. `abort` beats a simultaneous `start`.
- `start` outside IDLE is ignored.
- Dark value arithmetic: 8-bit unsigned min. Counter width is clog2(IMG_WIDTH*IMG_HEIGHT). The counter does not wrap because the FSM leaves ACCUM on the terminal count.
- Reset values: state IDLE; `in_ready`, `busy`, `done` and `a_valid` = 0; A_* and A_dc = 0; counter 0.

## Timing
- `in_ready` rises the cycle after the `start` edge (first cycle in ACCUM).
- `in_valid` gaps are legal; only the counter gates completion.
- Last-pixel handshake in cycle T:
  - DRAIN in T+1.
  - best registers final at the edge ending T+1.
  - `done`=1 and A_* valid in cycle T+2.
  - IDLE in T+3.
- A `start` in T+3 begins the next frame. Minimum frame period is N+3 cycles, where N = pixel count.
- `rst_n` low mid-frame: immediate return to reset values. Partial results are never published.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, ACCUM, DRAIN, DONE).
  - Channel width constant 8.
  - Channel select codes RED=0, GREEN=1, BLUE=2.
- Sub-module `dark_channel_min3`: combinational 3-input minimum returning the value and the select code. It is instantiated once in stage 1; ties resolve R, then G, then B.
- The top level holds the FSM, counter, stage-1 registers and best registers.

## Test plan
- 4x2 frame, all pixels (100,120,90) -> `done` at T+2, A=(100,120,90), A_dc=90, `a_valid`=1.
- 4x2 frame, last pixel (250,240,230), others dc ≤ 50 -> A=(250,240,230), A_dc=230.
- Tie: pixel 2 = (80,80,80), pixel 5 = (90,80,85), rest dc < 80 -> A=(80,80,80); earliest wins.
- Random `in_valid` gaps (~50% duty) on the 4x2 frame -> same A as the gap-free run; `done` exactly 2 cycles after the 8th handshake.
- `abort` after 3 pixels -> IDLE next cycle, no `done`, `a_valid`=0. A new `start` then runs a full frame correctly.
- `rst_n` pulsed low mid-frame, then `start` held high during ACCUM -> all outputs 0 after reset; `start` in ACCUM is ignored; the frame count is unaffected.
